vga_timing_multimode: RTL

VGA_TIMING_MULTIMODE -- requirements
Module: vga_timing_multimode

---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_axis_timing.sv | 25 ++
 rtl/vga_timing_multimode.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Mode table and helpers shared by the multimode VGA timing generator.
// Constants only: no latency, no backpressure.
package vga_timing_pkg;

    localparam int TW         = 16;
    localparam int TABLE_SIZE = 2;

    typedef struct packed {
        logic [TW-1:0] h_total, h_sync, h_bp, h_fp;
        logic [TW-1:0] v_total, v_sync, v_bp, v_fp;
        logic          h_pol, v_pol;
    } timing_t;

    // Polarity 1 means the sync pulse is driven high.
    localparam timing_t MODE_TABLE [TABLE_SIZE] = '{
        '{h_total: 16'd800,  h_sync: 16'd96,  h_bp: 16'd48, h_fp: 16'd16,
          v_total: 16'd525,  v_sync: 16'd2,   v_bp: 16'd33, v_fp: 16'd10,
          h_pol: 1'b0, v_pol: 1'b0},
        '{h_total: 16'd1056, h_sync: 16'd128, h_bp: 16'd88, h_fp: 16'd40,
          v_total: 16'd628,  v_sync: 16'd4,   v_bp: 16'd23, v_fp: 16'd1,
          h_pol: 1'b1, v_pol: 1'b1}
    };

    function automatic int mode_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit table_fits(input int n, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        if (n < 1 || n > TABLE_SIZE) return 1'b0;
        for (int i = 0; i < n; i++) begin
            if (longint'(MODE_TABLE[i].h_total) > lim || longint'(MODE_TABLE[i].v_total) > lim)
                return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/vga_axis_timing.sv
// One timing axis: sync level, active flag and visible coordinate from a count.
// Purely combinational (latency 0); no backpressure.
module vga_axis_timing #(
    parameter int CNT_W = 12
) (
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] total_i,
    input  logic [CNT_W-1:0] sync_i,
    input  logic [CNT_W-1:0] bp_i,
    input  logic [CNT_W-1:0] fp_i,
    input  logic             pol_i,
    output logic             sync_o,
    output logic             active_o,
    output logic [CNT_W-1:0] coord_o
);

    logic [CNT_W-1:0] start, stop;

    assign start    = sync_i + bp_i;
    assign stop     = total_i - fp_i;
    assign sync_o   = (cnt_i < sync_i) ? pol_i : ~pol_i;
    assign active_o = (cnt_i >= start) && (cnt_i < stop);
    assign coord_o  = active_o ? (cnt_i - start) : '0;

endmodule

// File: rtl/vga_timing_multimode.sv
// Free-running VGA timing generator with mode changes applied on frame boundaries.
// Outputs registered, latency 1 from counter state; no backpressure.
module vga_timing_multimode
    import vga_timing_pkg::*;
#(
    parameter int CNT_W      = 12,
    parameter int NUM_MODES  = 2,
    parameter int RESET_MODE = 0
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_mode_req,
    input  logic [mode_w(NUM_MODES)-1:0] i_mode,
    output logic                         o_mode_ack,
    output logic                         o_mode_err,
    output logic [mode_w(NUM_MODES)-1:0] o_mode,
    output logic                         o_hs,
    output logic                         o_vs,
    output logic                         o_activeArea,
    output logic [CNT_W-1:0]             o_px,
    output logic [CNT_W-1:0]             o_py,
    output logic                         o_lineStart,
    output logic                         o_frameStart
);

    localparam int MW = mode_w(NUM_MODES);

    if (!table_fits(NUM_MODES, CNT_W) || RESET_MODE < 0 || RESET_MODE >= NUM_MODES) begin : g_bad_cfg
        $error("vga_timing_multimode: mode table does not fit CNT_W or RESET_MODE out of range");
    end

    localparam timing_t RST_T = MODE_TABLE[RESET_MODE];

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [MW-1:0]    mode_q, mode_d, pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d, ack_q, ack_d, err_q, err_d;
    logic             hs_q, hs_d, vs_q, vs_d, act_q, act_d, ls_q, ls_d, fs_q, fs_d;
    logic [CNT_W-1:0] px_q, px_d, py_q, py_d;

    timing_t          cur;
    logic [CNT_W-1:0] h_tot, v_tot, h_coord, v_coord;
    logic             h_sync, v_sync, h_act, v_act, h_last, v_last;

    assign cur   = MODE_TABLE[mode_q];
    assign h_tot = CNT_W'(cur.h_total);
    assign v_tot = CNT_W'(cur.v_total);

    vga_axis_timing #(.CNT_W(CNT_W)) u_h_axis (
        .cnt_i   (h_q),
        .total_i (h_tot),
        .sync_i  (CNT_W'(cur.h_sync)),
        .bp_i    (CNT_W'(cur.h_bp)),
        .fp_i    (CNT_W'(cur.h_fp)),
        .pol_i   (cur.h_pol),
        .sync_o  (h_sync),
        .active_o(h_act),
        .coord_o (h_coord)
    );

    vga_axis_timing #(.CNT_W(CNT_W)) u_v_axis (
        .cnt_i   (v_q),
        .total_i (v_tot),
        .sync_i  (CNT_W'(cur.v_sync)),
        .bp_i    (CNT_W'(cur.v_bp)),
        .fp_i    (CNT_W'(cur.v_fp)),
        .pol_i   (cur.v_pol),
        .sync_o  (v_sync),
        .active_o(v_act),
        .coord_o (v_coord)
    );

    always_comb begin
        h_last     = (h_q == h_tot - CNT_W'(1));
        v_last     = (v_q == v_tot - CNT_W'(1));
        h_d        = h_last ? '0 : h_q + CNT_W'(1);
        v_d        = v_q;
        mode_d     = mode_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        if (h_last) v_d = v_last ? '0 : v_q + CNT_W'(1);
        // Apply uses the pending value from before this cycle, so a request
        // landing in the final frame cycle waits for the next boundary.
        if (h_last && v_last && pend_vld_q) begin
            mode_d     = pend_q;
            pend_vld_d = 1'b0;
            ack_d      = 1'b1;
        end
        if (i_mode_req) begin
            if (int'(i_mode) < NUM_MODES) begin
                pend_d     = i_mode;
                pend_vld_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        hs_d  = h_sync;
        vs_d  = v_sync;
        act_d = h_act && v_act;
        px_d  = act_d ? h_coord : '0;
        py_d  = act_d ? v_coord : '0;
        ls_d  = (h_q == '0);
        fs_d  = (h_q == '0) && (v_q == '0);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            h_q        <= '0;
            v_q        <= '0;
            mode_q     <= MW'(RESET_MODE);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            hs_q       <= ~RST_T.h_pol;
            vs_q       <= ~RST_T.v_pol;
            act_q      <= 1'b0;
            px_q       <= '0;
            py_q       <= '0;
            ls_q       <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            act_q      <= act_d;
            px_q       <= px_d;
            py_q       <= py_d;
            ls_q       <= ls_d;
            fs_q       <= fs_d;
        end
    end

    assign o_mode_ack   = ack_q;
    assign o_mode_err   = err_q;
    assign o_mode       = mode_q;
    assign o_hs         = hs_q;
    assign o_vs         = vs_q;
    assign o_activeArea = act_q;
    assign o_px         = px_q;
    assign o_py         = py_q;
    assign o_lineStart  = ls_q;
    assign o_frameStart = fs_q;

endmodule
